// File: rtl/ascon_io_bridge.sv
// Lane-parallel load/unload bridge between pad streams and a parallel Ascon AEAD core.
// Optional watchdog in WAIT: define ASCON_BRIDGE_TIMEOUT_EN.
module ascon_io_bridge #(
   parameter int unsigned LANES          = 1,
   parameter int unsigned KEY_BITS       = 128,
   parameter int unsigned DATA_BITS      = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [LANES-1:0]     key_in,
   input  logic [LANES-1:0]     nonce_in,
   input  logic [LANES-1:0]     ad_in,
   input  logic [LANES-1:0]     data_in,
   input  logic [LANES-1:0]     tag_in,
   input  logic                 decrypt,
   input  logic                 start,
   output logic                 ready,
   output logic                 loaded,
   output logic                 out_valid,
   output logic [LANES-1:0]     data_out,
   output logic [LANES-1:0]     tag_out,
   output logic                 auth_fail,
   output logic [KEY_BITS-1:0]  core_key,
   output logic [KEY_BITS-1:0]  core_nonce,
   output logic [DATA_BITS-1:0] core_ad,
   output logic [DATA_BITS-1:0] core_data,
   output logic                 core_decrypt,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic [DATA_BITS-1:0] core_data_out,
   input  logic [KEY_BITS-1:0]  core_tag_out
`ifdef ASCON_BRIDGE_TIMEOUT_EN
   ,
   output logic                 timeout
`endif
);

   localparam int unsigned LB = KEY_BITS / LANES;
   localparam int unsigned DB = DATA_BITS / LANES;
   localparam int unsigned BW = $clog2(LB + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_WAIT, S_SHIFT} state_t;

   state_t                r_state;
   logic [BW-1:0]         r_beat;
   logic                  r_ready;
   logic                  r_loaded;
   logic                  r_out_valid;
   logic [LANES-1:0]      r_data_out;
   logic [LANES-1:0]      r_tag_out;
   logic                  r_auth_fail;
   logic [KEY_BITS-1:0]   r_core_key;
   logic [KEY_BITS-1:0]   r_core_nonce;
   logic [DATA_BITS-1:0]  r_core_ad;
   logic [DATA_BITS-1:0]  r_core_data;
   logic                  r_core_decrypt;
   logic                  r_core_start;
   logic [KEY_BITS-1:0]   r_tag;
   logic [DATA_BITS-1:0]  r_dsh;
   logic [KEY_BITS-1:0]   r_tsh;

   logic [BW-1:0]         w_beat_inc;
   logic                  w_load_last;
   logic                  w_data_live;
   logic                  w_fail;
   logic                  w_shift_last;

   assign w_beat_inc   = r_beat + BW'(1);
   assign w_load_last  = (r_beat == BW'(LB - 1));
   assign w_data_live  = (r_beat < BW'(DB));
   assign w_shift_last = (r_beat == BW'(LB));
   assign w_fail       = r_core_decrypt && (core_tag_out != r_tag);

`ifdef ASCON_BRIDGE_TIMEOUT_EN
   localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] r_wd;
   logic           r_timeout;
   assign timeout = r_timeout;
`endif

   // The core_* operand registers double as the load shift registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_beat         <= '0;
         r_ready        <= 1'b1;
         r_loaded       <= 1'b0;
         r_out_valid    <= 1'b0;
         r_data_out     <= '0;
         r_tag_out      <= '0;
         r_auth_fail    <= 1'b0;
         r_core_key     <= '0;
         r_core_nonce   <= '0;
         r_core_ad      <= '0;
         r_core_data    <= '0;
         r_core_decrypt <= 1'b0;
         r_core_start   <= 1'b0;
         r_tag          <= '0;
         r_dsh          <= '0;
         r_tsh          <= '0;
`ifdef ASCON_BRIDGE_TIMEOUT_EN
         r_wd           <= '0;
         r_timeout      <= 1'b0;
`endif
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            S_IDLE, S_LOAD: begin
               if (in_valid) begin
                  if (r_state == S_IDLE) begin
                     r_auth_fail <= 1'b0;
`ifdef ASCON_BRIDGE_TIMEOUT_EN
                     r_timeout   <= 1'b0;
`endif
                  end
                  r_ready      <= 1'b0;
                  r_core_key   <= {r_core_key[KEY_BITS-LANES-1:0], key_in};
                  r_core_nonce <= {r_core_nonce[KEY_BITS-LANES-1:0], nonce_in};
                  r_tag        <= {r_tag[KEY_BITS-LANES-1:0], tag_in};
                  if (w_data_live) begin
                     r_core_ad   <= {r_core_ad[DATA_BITS-LANES-1:0], ad_in};
                     r_core_data <= {r_core_data[DATA_BITS-LANES-1:0], data_in};
                  end
                  if (w_load_last) begin
                     r_beat   <= '0;
                     r_loaded <= 1'b1;
                     r_state  <= S_ARMED;
                  end else begin
                     r_beat  <= w_beat_inc;
                     r_state <= S_LOAD;
                  end
               end
            end
            S_ARMED: begin
               if (start) begin
                  r_core_decrypt <= decrypt;
                  r_core_start   <= 1'b1;
                  r_loaded       <= 1'b0;
                  r_state        <= S_WAIT;
`ifdef ASCON_BRIDGE_TIMEOUT_EN
                  r_wd           <= '0;
`endif
               end
            end
            S_WAIT: begin
               // Beat 0 is presented straight from the core so out_valid spans exactly LB cycles.
               if (core_done) begin
                  r_auth_fail <= w_fail;
                  r_out_valid <= 1'b1;
                  r_tag_out   <= core_tag_out[KEY_BITS-1 -: LANES];
                  r_data_out  <= w_fail ? '0 : core_data_out[DATA_BITS-1 -: LANES];
                  r_tsh       <= core_tag_out << LANES;
                  r_dsh       <= core_data_out << LANES;
                  r_beat      <= BW'(1);
                  r_state     <= S_SHIFT;
               end
`ifdef ASCON_BRIDGE_TIMEOUT_EN
               else if (r_wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                  r_timeout <= 1'b1;
                  r_ready   <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_wd <= r_wd + WDW'(1);
               end
`endif
            end
            S_SHIFT: begin
               if (w_shift_last) begin
                  r_out_valid <= 1'b0;
                  r_tag_out   <= '0;
                  r_data_out  <= '0;
                  r_beat      <= '0;
                  r_ready     <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_tag_out  <= r_tsh[KEY_BITS-1 -: LANES];
                  r_data_out <= (w_data_live && !r_auth_fail) ? r_dsh[DATA_BITS-1 -: LANES] : '0;
                  r_tsh      <= r_tsh << LANES;
                  r_dsh      <= r_dsh << LANES;
                  r_beat     <= w_beat_inc;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready        = r_ready;
   assign loaded       = r_loaded;
   assign out_valid    = r_out_valid;
   assign data_out     = r_data_out;
   assign tag_out      = r_tag_out;
   assign auth_fail    = r_auth_fail;
   assign core_key     = r_core_key;
   assign core_nonce   = r_core_nonce;
   assign core_ad      = r_core_ad;
   assign core_data    = r_core_data;
   assign core_decrypt = r_core_decrypt;
   assign core_start   = r_core_start;

endmodule

// File: tb/tb_ascon_io_bridge.sv
// Directed bench for ascon_io_bridge at LANES=4; watchdog path under ASCON_BRIDGE_TIMEOUT_EN.
module tb_ascon_io_bridge;

   localparam int unsigned L  = 4;
   localparam int unsigned LB = 32;
   localparam int unsigned DB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [L-1:0]  key_in, nonce_in, ad_in, data_in, tag_in;
   logic          decrypt, start;
   logic          ready, loaded, out_valid, auth_fail;
   logic [L-1:0]  data_out, tag_out;
   logic [127:0]  core_key, core_nonce, core_tag_out;
   logic [63:0]   core_ad, core_data, core_data_out;
   logic          core_decrypt, core_start, core_done;
`ifdef ASCON_BRIDGE_TIMEOUT_EN
   logic          timeout;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ascon_io_bridge #(
      .LANES(L), .KEY_BITS(128), .DATA_BITS(64)
`ifdef ASCON_BRIDGE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .data_in(data_in), .tag_in(tag_in),
      .decrypt(decrypt), .start(start), .ready(ready), .loaded(loaded),
      .out_valid(out_valid), .data_out(data_out), .tag_out(tag_out), .auth_fail(auth_fail),
      .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_data(core_data),
      .core_decrypt(core_decrypt), .core_start(core_start), .core_done(core_done),
      .core_data_out(core_data_out), .core_tag_out(core_tag_out)
`ifdef ASCON_BRIDGE_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic load_op(input logic [127:0] k, input logic [127:0] n, input logic [127:0] t,
                          input logic [63:0] a, input logic [63:0] d, input bit gap);
      for (int b = 0; b < int'(LB); b++) begin
         @(negedge clk);
         if (gap && b == int'(LB) - 1) chk("loaded_before_last", 128'(loaded), 128'd0);
         in_valid = 1'b1;
         key_in   = k[127-4*b -: 4];
         nonce_in = n[127-4*b -: 4];
         tag_in   = t[127-4*b -: 4];
         if (b < int'(DB)) begin
            ad_in   = a[63-4*b -: 4];
            data_in = d[63-4*b -: 4];
         end else begin
            ad_in   = 4'hF;
            data_in = 4'hC;
         end
         if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            key_in = 4'h7; nonce_in = 4'h7; tag_in = 4'h7; ad_in = 4'h7; data_in = 4'h7;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_op(input bit dec, input logic [63:0] rd, input logic [127:0] rt,
                         output logic [127:0] gd, output logic [127:0] gt, output int nv);
      @(negedge clk);
      start = 1'b1; decrypt = dec;
      in_valid = 1'b1; key_in = 4'hF;
      @(negedge clk);
      start = 1'b0; decrypt = 1'b0; in_valid = 1'b0;
      chk("core_start_pulse", 128'(core_start), 128'd1);
      chk("loaded_cleared", 128'(loaded), 128'd0);
      @(negedge clk);
      chk("core_start_single", 128'(core_start), 128'd0);
      chk("core_decrypt", 128'(core_decrypt), 128'(dec));
      repeat (8) @(negedge clk);
      core_done = 1'b1; core_data_out = rd; core_tag_out = rt;
      @(negedge clk);
      core_done = 1'b0; core_data_out = '0; core_tag_out = '0;
      gd = '0; gt = '0; nv = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            nv++;
            gd = {gd[123:0], data_out};
            gt = {gt[123:0], tag_out};
         end
         @(negedge clk);
      end
   endtask

   localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] N1 = 128'h101112131415161718191A1B1C1D1E1F;
   localparam logic [63:0]  A1 = 64'hA5A5A5A5A5A5A5A5;
   localparam logic [63:0]  D1 = 64'h0123456789ABCDEF;
   localparam logic [63:0]  R1 = 64'hFEDCBA9876543210;
   localparam logic [127:0] T1 = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
   localparam logic [127:0] K2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
   localparam logic [127:0] N2 = 128'h55AA55AA33CC33CC0FF00FF012481248;
   localparam logic [63:0]  A2 = 64'h1357924680ACE0DF;
   localparam logic [63:0]  D2 = 64'hC0FFEE00BEEF1234;
   localparam logic [63:0]  R2 = 64'h0011223344556677;
   localparam logic [127:0] T2 = 128'h8899AABBCCDDEEFF0123456789ABCDEF;

   initial begin
      logic [127:0] gd, gt;
      int nv;
      rst = 1'b1; in_valid = 1'b0; start = 1'b0; decrypt = 1'b0; core_done = 1'b0;
      key_in = '0; nonce_in = '0; ad_in = '0; data_in = '0; tag_in = '0;
      core_data_out = '0; core_tag_out = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(ready), 128'd1);
      chk("rst_loaded", 128'(loaded), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_core_start", 128'(core_start), 128'd0);
      chk("rst_core_key", core_key, 128'd0);
      chk("rst_core_data", 128'(core_data), 128'd0);
      chk("rst_outs", 128'({auth_fail, data_out, tag_out}), 128'd0);
      rst = 1'b0;

      // stray start / core_done in IDLE
      @(negedge clk); start = 1'b1; core_done = 1'b1; core_tag_out = T1;
      @(negedge clk); start = 1'b0; core_done = 1'b0; core_tag_out = '0;
      chk("idle_start_ignored", 128'(core_start), 128'd0);
      chk("idle_done_ignored", 128'(out_valid), 128'd0);
      chk("idle_ready", 128'(ready), 128'd1);

      // encrypt, continuous load
      load_op(K1, N1, T1, A1, D1, 1'b0);
      chk("enc_loaded", 128'(loaded), 128'd1);
      chk("enc_ready_low", 128'(ready), 128'd0);
      chk("enc_key", core_key, K1);
      chk("enc_nonce", core_nonce, N1);
      chk("enc_ad", 128'(core_ad), 128'(A1));
      chk("enc_data", 128'(core_data), 128'(D1));
      run_op(1'b0, R1, T1, gd, gt, nv);
      chk("enc_beats", 128'(nv), 128'd32);
      chk("enc_data_out", gd, {R1, 64'h0});
      chk("enc_tag_out", gt, T1);
      chk("enc_ready_after", 128'(ready), 128'd1);
      chk("enc_auth_fail", 128'(auth_fail), 128'd0);
      chk("enc_key_held", core_key, K1);

      // decrypt with matching tag, gapped load
      load_op(K2, N2, T2, A2, D2, 1'b1);
      chk("gap_loaded", 128'(loaded), 128'd1);
      chk("gap_key", core_key, K2);
      chk("gap_nonce", core_nonce, N2);
      chk("gap_ad", 128'(core_ad), 128'(A2));
      chk("gap_data", 128'(core_data), 128'(D2));
      run_op(1'b1, R2, T2, gd, gt, nv);
      chk("dec_ok_beats", 128'(nv), 128'd32);
      chk("dec_ok_data_out", gd, {R2, 64'h0});
      chk("dec_ok_tag_out", gt, T2);
      chk("dec_ok_auth_fail", 128'(auth_fail), 128'd0);

      // decrypt with tag differing in the LSB
      load_op(K2, N2, T2 ^ 128'd1, A2, D2, 1'b0);
      run_op(1'b1, R2, T2, gd, gt, nv);
      chk("dec_bad_beats", 128'(nv), 128'd32);
      chk("dec_bad_auth_fail", 128'(auth_fail), 128'd1);
      chk("dec_bad_data_out", gd, 128'd0);
      chk("dec_bad_tag_out", gt, T2);
      repeat (3) @(negedge clk);
      chk("auth_fail_sticky", 128'(auth_fail), 128'd1);

      // async reset in WAIT, then a late core_done
      load_op(K1, N1, T1, A1, D1, 1'b0);
      chk("reload_clears_auth", 128'(auth_fail), 128'd0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst_ready", 128'(ready), 128'd1);
      @(negedge clk); rst = 1'b0;
      core_done = 1'b1; core_data_out = R1; core_tag_out = T1;
      @(negedge clk); core_done = 1'b0; core_data_out = '0; core_tag_out = '0;
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) nv++;
         @(negedge clk);
      end
      chk("rst_wait_no_output", 128'(nv), 128'd0);
      chk("rst_wait_ready", 128'(ready), 128'd1);
      chk("rst_wait_core_key", core_key, 128'd0);
      chk("rst_wait_flags", 128'({loaded, core_decrypt, auth_fail, data_out, tag_out}), 128'd0);

`ifdef ASCON_BRIDGE_TIMEOUT_EN
      load_op(K1, N1, T1, A1, D1, 1'b0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (timeout) begin
            nv = i + 1;
            break;
         end
      end
      chk("timeout_cycles", 128'(nv), 128'd16);
      chk("timeout_ready", 128'(ready), 128'd1);
      chk("timeout_no_output", 128'(out_valid), 128'd0);
      @(negedge clk); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      chk("timeout_cleared", 128'(timeout), 128'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ascon_io_bridge.md
Name: ascon_io_bridge

Overview:
- Parametrised serial-to-parallel front end for the Ascon AEAD core in the user area.
- Deserialises the key, nonce, associated data, data block and (for decrypt) expected tag from LANES-bit pad lanes, then runs a start/done handshake with a parallel Ascon core.
- Serialises the result and tag back to pads.
- Successor to the 1-bit serial Ascon pad wrapper: adds variable lane width, explicit load/output framing, and on-chip tag verification for decrypt.

Parameters:
- LANES, 1, bits per beat per stream; legal values 1, 2, 4, 8.
- KEY_BITS, 128, key, nonce and tag width.
- DATA_BITS, 64, associated-data and data block width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with ASCON_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  load beat strobe.
- key_in  in  LANES  key stream, MSB first.
- nonce_in  in  LANES  nonce stream, MSB first.
- ad_in  in  LANES  associated-data stream, MSB first.
- data_in  in  LANES  plaintext/ciphertext stream, MSB first.
- tag_in  in  LANES  expected-tag stream, MSB first.
- decrypt  in  1  mode; sampled with start.
- start  in  1  launch request.
- ready  out  1  idle, accepting a new load.
- loaded  out  1  all operands captured, waiting for start.
- out_valid  out  1  output beat valid.
- data_out  out  LANES  result stream, MSB first.
- tag_out  out  LANES  computed tag stream, MSB first.
- auth_fail  out  1  decrypt tag mismatch, sticky until next load.
- core_key  out  KEY_BITS  to core.
- core_nonce  out  KEY_BITS  to core.
- core_ad  out  DATA_BITS  to core.
- core_data  out  DATA_BITS  to core.
- core_decrypt  out  1  to core.
- core_start  out  1  one-cycle pulse to core.
- core_done  in  1  one-cycle pulse from core.
- core_data_out  in  DATA_BITS  core result.
- core_tag_out  in  KEY_BITS  core tag.
- timeout  out  1  watchdog fired; exists only with ASCON_BRIDGE_TIMEOUT_EN.

Behaviour:
- Reset (async, active-high) state:
  - FSM = IDLE; ready=1.
  - All other outputs 0, including every core_* register and all shift registers.
  - Beat counters = 0.
- Beat counts:
  - LB = KEY_BITS/LANES, load beats.
  - DB = DATA_BITS/LANES, data beats.
- FSM transitions:
  - IDLE: first in_valid beat is captured and the FSM moves to LOAD. auth_fail and timeout clear on this beat.
  - LOAD: one beat per in_valid cycle; in_valid low pauses with no loss. Key, nonce and tag shift every beat. AD and data shift only on beats 0..DB-1 and are ignored after that. After beat LB-1, go to ARMED and set loaded=1.
  - ARMED: in_valid ignored. On start=1, latch decrypt into core_decrypt, pulse core_start for exactly 1 cycle, clear loaded, go to WAIT.
  - WAIT: on core_done, capture core_data_out and core_tag_out into output shift registers and go to SHIFT. In decrypt mode the same cycle sets auth_fail = (core_tag_out != captured tag).
  - SHIFT: out_valid=1 for exactly LB consecutive cycles.
    - tag_out presents successive MSB-first LANES slices.
    - data_out carries slices for the first DB cycles, then 0.
    - After the last beat, go to IDLE with ready=1.
- Decrypt output gating: in decrypt mode with auth_fail=1, data_out is forced to 0 for the whole SHIFT phase; tag_out is still driven.
- Ignored inputs:
  - start outside ARMED.
  - core_done outside WAIT.
  - in_valid outside IDLE/LOAD.
- Simultaneous in_valid and start in ARMED: start wins; the beat is dropped.
- core_* operand outputs hold their values from ARMED until the next load begins.
- Reset mid-operation: immediate return to reset state. A core_done arriving later is ignored because the FSM is in IDLE.
- ready is 1 only in IDLE.

Optional Feature:
- ASCON_BRIDGE_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If core_done has not arrived when the counter reaches TIMEOUT_CYCLES, set timeout=1 (sticky until the next load) and go to IDLE; no output phase.
- Undefined: WAIT persists until core_done or reset; no timeout port and no counter.

Test Plan:
- LANES=1, encrypt:
  - Stimulus: 128 beats with key=000102..0F, nonce=101112..1F, ad=0xA5A5A5A5A5A5A5A5, data=0x0123456789ABCDEF; start; core model returns data_out=0xFEDCBA9876543210 and a tag after 10 cycles.
  - Required: core_start high for 1 cycle; 128 out_valid beats; data bits match for beats 0..63, then 0; ready=1 after.
- LANES=4, decrypt, matching tag: 32 load beats -> core_decrypt=1, auth_fail=0, 32 output beats, 16 data nibbles released.
- LANES=4, decrypt, tag_in differing in the LSB: auth_fail=1, data_out=0 on all 32 beats, tag_out still driven.
- in_valid toggling 1/0 during load (LANES=2): loaded rises only after the 64th valid beat; captured operands are identical to the continuous-load case.
- Async rst pulsed mid-WAIT, then core_done: FSM in IDLE, out_valid stays 0, all outputs 0, ready=1.
- With ASCON_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_done never asserted: timeout=1 after 16 WAIT cycles, ready=1; timeout clears on the next in_valid beat.
